// File: rtl/alu_op_sequencer_pkg.sv
// Purpose : shared encodings for the ALU operation sequencer (op codes, FSM states, timer width).
// Latency : n/a (declarations only).
// Backpr. : n/a.
package alu_op_sequencer_pkg;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_MUL = 3'd2;
   localparam logic [2:0] OP_DIV = 3'd3;
   localparam logic [2:0] OP_MOD = 3'd4;

   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Codes above OP_MOD have no datapath unit behind them.
   function automatic logic is_legal_op(input logic [2:0] op);
      return (op <= OP_MOD);
   endfunction

endpackage

// File: rtl/alu_seq_timer.sv
// Purpose : loadable down-counter that times how long the datapath settles in EXEC.
// Latency : load/decrement take effect on the next clock edge; o_zero is combinational from the count.
// Backpr. : none; the count saturates at zero while enabled.
// Ports   : i_load/i_load_val load the count (load wins over enable), i_en decrements, o_zero flags count==0.
module alu_seq_timer
   import alu_op_sequencer_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_en,
   output logic             o_zero
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_en && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// Purpose : accepts one ADD/SUB/MUL/DIV/MOD request, times the combinational unit, returns result + flags.
// Latency : ADDSUB_LAT / MUL_LAT / DIVMOD_LAT cycles from accept to rsp_valid; error ops go straight to response.
// Backpr. : req_ready only in IDLE; the response is held stable until rsp_ready, no accept on the retire cycle.
// Ports   : req_* request handshake + operands, rsp_* response handshake + result/carry/overflow/err, busy = not IDLE.
// Config  : ALU_OP_SEQUENCER_ACCUM_EN adds a 16-bit accumulator and req_use_acc (A = acc when set at accept).
module alu_op_sequencer
   import alu_op_sequencer_pkg::*;
#(
   parameter int unsigned ADDSUB_LAT = 1,
   parameter int unsigned MUL_LAT    = 4,
   parameter int unsigned DIVMOD_LAT = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [15:0] req_a,
   input  logic [15:0] req_b,
`ifdef ALU_OP_SEQUENCER_ACCUM_EN
   input  logic        req_use_acc,
`endif
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_result,
   output logic        rsp_carry,
   output logic        rsp_overflow,
   output logic        rsp_err,
   output logic        busy
);

   localparam logic [CNT_W-1:0] L_ADDSUB = CNT_W'(ADDSUB_LAT - 1);
   localparam logic [CNT_W-1:0] L_MUL    = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0] L_DIVMOD = CNT_W'(DIVMOD_LAT - 1);

   state_t            r_state, w_state_nxt;
   logic [2:0]        r_op;
   logic [15:0]       r_a, r_b;
   logic [31:0]       r_rsp_result;
   logic              r_rsp_carry, r_rsp_overflow, r_rsp_err;

   logic              w_accept, w_err_in, w_tmr_load, w_tmr_en, w_tmr_zero;
   logic              w_cap_unit, w_cap_err;
   logic [15:0]       w_a_in;
   logic [CNT_W-1:0]  w_lat_m1;

   // ---------------------------------------------------------------- accept side
   assign w_accept = req_valid && (r_state == ST_IDLE);

`ifdef ALU_OP_SEQUENCER_ACCUM_EN
   logic [15:0] r_acc;
   assign w_a_in = req_use_acc ? r_acc : req_a;
`else
   assign w_a_in = req_a;
`endif

   // Zero divisor is caught here so the divider never has to report it.
   assign w_err_in = !is_legal_op(req_op) ||
                     (((req_op == OP_DIV) || (req_op == OP_MOD)) && (req_b == 16'd0));

   always_comb begin
      w_lat_m1 = L_ADDSUB;
      case (req_op)
         OP_MUL:         w_lat_m1 = L_MUL;
         OP_DIV, OP_MOD: w_lat_m1 = L_DIVMOD;
         default:        w_lat_m1 = L_ADDSUB;
      endcase
   end

   alu_seq_timer u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_tmr_load),
      .i_load_val (w_lat_m1),
      .i_en       (w_tmr_en),
      .o_zero     (w_tmr_zero)
   );

   // ---------------------------------------------------------------- arithmetic units (registered operands only)
   // AddSub: subtract as A + ~B + 1, so carry is "no borrow".
   logic        w_sub;
   logic [15:0] w_b_eff, w_sum;
   logic [16:0] w_addsub_full;
   logic        w_as_carry, w_as_ovf;

   assign w_sub         = (r_op == OP_SUB);
   assign w_b_eff       = w_sub ? ~r_b : r_b;
   assign w_addsub_full = {1'b0, r_a} + {1'b0, w_b_eff} + {16'd0, w_sub};
   assign w_sum         = w_addsub_full[15:0];
   assign w_as_carry    = w_addsub_full[16];
   assign w_as_ovf      = (r_a[15] == w_b_eff[15]) && (w_sum[15] != r_a[15]);

   // Multiplier: full unsigned product.
   logic [31:0] w_prod;
   assign w_prod = {16'd0, r_a} * {16'd0, r_b};

   // Divider / Modder: divisor is never zero in EXEC; the guard only keeps X out of simulation.
   logic [15:0] w_quot, w_rem;
   assign w_quot = (r_b == 16'd0) ? 16'd0 : (r_a / r_b);
   assign w_rem  = (r_b == 16'd0) ? 16'd0 : (r_a % r_b);

   logic [31:0] w_unit_result;
   logic        w_unit_carry, w_unit_ovf;

   always_comb begin
      w_unit_result = 32'd0;
      w_unit_carry  = 1'b0;
      w_unit_ovf    = 1'b0;
      case (r_op)
         OP_ADD, OP_SUB: begin
            w_unit_result = {16'd0, w_sum};
            w_unit_carry  = w_as_carry;
            w_unit_ovf    = w_as_ovf;
         end
         OP_MUL:  w_unit_result = w_prod;
         OP_DIV:  w_unit_result = {16'd0, w_quot};
         OP_MOD:  w_unit_result = {16'd0, w_rem};
         default: w_unit_result = 32'd0;
      endcase
   end

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_tmr_load  = 1'b0;
      w_tmr_en    = 1'b0;
      w_cap_unit  = 1'b0;
      w_cap_err   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               if (w_err_in) begin
                  w_cap_err   = 1'b1;
                  w_state_nxt = ST_RESP;
               end else begin
                  w_tmr_load  = 1'b1;
                  w_state_nxt = ST_EXEC;
               end
            end
         end
         ST_EXEC: begin
            w_tmr_en = 1'b1;
            if (w_tmr_zero) begin
               w_cap_unit  = 1'b1;
               w_state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            if (rsp_ready) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- operand / response registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op           <= OP_ADD;
         r_a            <= 16'd0;
         r_b            <= 16'd0;
         r_rsp_result   <= 32'd0;
         r_rsp_carry    <= 1'b0;
         r_rsp_overflow <= 1'b0;
         r_rsp_err      <= 1'b0;
      end else begin
         if (w_accept) begin
            r_op <= req_op;
            r_a  <= w_a_in;
            r_b  <= req_b;
         end
         if (w_cap_err) begin
            r_rsp_result   <= 32'd0;
            r_rsp_carry    <= 1'b0;
            r_rsp_overflow <= 1'b0;
            r_rsp_err      <= 1'b1;
         end else if (w_cap_unit) begin
            r_rsp_result   <= w_unit_result;
            r_rsp_carry    <= w_unit_carry;
            r_rsp_overflow <= w_unit_ovf;
            r_rsp_err      <= 1'b0;
         end
      end
   end

`ifdef ALU_OP_SEQUENCER_ACCUM_EN
   // Only successful captures feed the accumulator.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          r_acc <= 16'd0;
      else if (w_cap_unit) r_acc <= w_unit_result[15:0];
   end
`endif

   assign req_ready    = (r_state == ST_IDLE);
   assign rsp_valid    = (r_state == ST_RESP);
   assign busy         = (r_state != ST_IDLE);
   assign rsp_result   = r_rsp_result;
   assign rsp_carry    = r_rsp_carry;
   assign rsp_overflow = r_rsp_overflow;
   assign rsp_err      = r_rsp_err;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Purpose : directed self-checking bench for alu_op_sequencer (default latencies 1/4/2).
// Latency : inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpr. : bench drives rsp_ready explicitly, including a multi-cycle hold.
module tb_alu_op_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready;
   logic [2:0]  req_op;
   logic [15:0] req_a, req_b;
   logic        req_use_acc;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_result;
   logic        rsp_carry, rsp_overflow, rsp_err, busy;

   int n_vec = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   alu_op_sequencer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_op       (req_op),
      .req_a        (req_a),
      .req_b        (req_b),
`ifdef ALU_OP_SEQUENCER_ACCUM_EN
      .req_use_acc  (req_use_acc),
`endif
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_result   (rsp_result),
      .rsp_carry    (rsp_carry),
      .rsp_overflow (rsp_overflow),
      .rsp_err      (rsp_err),
      .busy         (busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present one request and return just after the accept edge.
   task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, input logic use_acc);
      int w;
      w = 0;
      while (!req_ready && w < 20) begin
         tick();
         w++;
      end
      chk("req_ready_before_send", {31'd0, req_ready}, 32'd1);
      req_valid   = 1'b1;
      req_op      = op;
      req_a       = a;
      req_b       = b;
      req_use_acc = use_acc;
      tick();
      req_valid   = 1'b0;
      req_use_acc = 1'b0;
   endtask

   // Edges after the accept edge until rsp_valid is seen (bounded).
   task automatic wait_rsp(output int cyc);
      cyc = 0;
      while (!rsp_valid && cyc < 40) begin
         tick();
         cyc++;
      end
   endtask

   task automatic retire();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   initial begin
      int cyc;
      int seen;

      rst_n = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_a = 16'd0; req_b = 16'd0;
      req_use_acc = 1'b0; rsp_ready = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();

      // Reset state
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_result",    rsp_result,          32'd0);
      chk("rst_busy",      {31'd0, busy},       32'd0);
      chk("rst_flags",     {29'd0, rsp_carry, rsp_overflow, rsp_err}, 32'd0);

      // ADD 0x0010 + 0x0005
      send(3'd0, 16'h0010, 16'h0005, 1'b0);
      chk("add_busy", {31'd0, busy}, 32'd1);
      wait_rsp(cyc);
      chk("add_lat",    32'(cyc),   32'd1);
      chk("add_result", rsp_result, 32'h0000_0015);
      chk("add_flags",  {29'd0, rsp_carry, rsp_overflow, rsp_err}, 32'd0);
      retire();

      // SUB 0x0003 - 0x0005: borrow -> carry 0, no signed overflow
      send(3'd1, 16'h0003, 16'h0005, 1'b0);
      wait_rsp(cyc);
      chk("sub1_lat",    32'(cyc),   32'd1);
      chk("sub1_result", rsp_result, 32'h0000_FFFE);
      chk("sub1_flags",  {29'd0, rsp_carry, rsp_overflow, rsp_err}, 32'd0);
      retire();

      // SUB 0x8000 - 0x0001: signed overflow, no borrow -> carry 1
      send(3'd1, 16'h8000, 16'h0001, 1'b0);
      wait_rsp(cyc);
      chk("sub2_result", rsp_result, 32'h0000_7FFF);
      chk("sub2_flags",  {29'd0, rsp_carry, rsp_overflow, rsp_err}, 32'b110);
      retire();

      // MUL 0x1234 * 0x0100
      send(3'd2, 16'h1234, 16'h0100, 1'b0);
      wait_rsp(cyc);
      chk("mul_lat",    32'(cyc),   32'd4);
      chk("mul_result", rsp_result, 32'h0012_3400);
      chk("mul_flags",  {29'd0, rsp_carry, rsp_overflow, rsp_err}, 32'd0);
      retire();

      // DIV by zero: response in the cycle right after accept, err set, result cleared
      send(3'd3, 16'h0010, 16'h0000, 1'b0);
      chk("div0_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("div0_result",    rsp_result,          32'd0);
      chk("div0_flags",     {29'd0, rsp_carry, rsp_overflow, rsp_err}, 32'b001);
      retire();

      // DIV 100 / 7 = 14
      send(3'd3, 16'd100, 16'd7, 1'b0);
      wait_rsp(cyc);
      chk("div_lat",    32'(cyc),   32'd2);
      chk("div_result", rsp_result, 32'd14);
      chk("div_err",    {31'd0, rsp_err}, 32'd0);
      retire();

      // Illegal op 6
      send(3'd6, 16'h1111, 16'h2222, 1'b0);
      chk("ill_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("ill_result",    rsp_result,          32'd0);
      chk("ill_err",       {31'd0, rsp_err},    32'd1);
      retire();

      // Remainder 0x0011 % 0x0005 with response held 3 cycles and a competing request
      send(3'd4, 16'h0011, 16'h0005, 1'b0);
      wait_rsp(cyc);
      chk("mod_lat", 32'(cyc), 32'd2);
      req_valid = 1'b1; req_op = 3'd0; req_a = 16'h0100; req_b = 16'h0001;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("mod_hold_result",    rsp_result,           32'h0000_0002);
         chk("mod_hold_rsp_valid", {31'd0, rsp_valid},   32'd1);
         chk("mod_hold_req_ready", {31'd0, req_ready},   32'd0);
      end
      retire();
      chk("mod_retired_valid",  {31'd0, rsp_valid}, 32'd0);
      chk("mod_retired_result", rsp_result,          32'h0000_0002);
      chk("mod_retired_ready",  {31'd0, req_ready}, 32'd1);
      tick();
      req_valid = 1'b0;
      wait_rsp(cyc);
      chk("held_add_lat",    32'(cyc),   32'd1);
      chk("held_add_result", rsp_result, 32'h0000_0101);
      retire();

      // Reset during EXEC of a MUL: op dropped, no response afterwards
      send(3'd2, 16'd2, 16'd3, 1'b0);
      tick();
      chk("mul_inflight_busy", {31'd0, busy}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_busy",      {31'd0, busy},      32'd0);
      chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("midrst_req_ready", {31'd0, req_ready}, 32'd1);
      tick();
      #3 rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (rsp_valid) seen++;
      end
      chk("midrst_no_rsp", 32'(seen), 32'd0);

`ifdef ALU_OP_SEQUENCER_ACCUM_EN
      // Accumulator: 5+3 -> acc=8, then acc+2 = 0xA
      send(3'd0, 16'd5, 16'd3, 1'b0);
      wait_rsp(cyc);
      chk("acc1_result", rsp_result, 32'd8);
      retire();
      send(3'd0, 16'hFFFF, 16'd2, 1'b1);
      wait_rsp(cyc);
      chk("acc2_result", rsp_result, 32'h0000_000A);
      retire();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
